fetch_unit: RTL and testbench

//  Initiator side of the instruction-memory interface: owns the fetch PC and drives byte address to ins_mem.

---
 rtl/rv_fetch_pkg.sv | 11 +
 rtl/fetch_unit_if.sv | 20 ++
 rtl/fetch_fifo.sv | 42 ++++
 rtl/fetch_unit.sv | 53 +++++
 tb/tb_fetch_unit.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/rv_fetch_pkg.sv
// rv_fetch_pkg: shared fetch-entry type and fetch constants
package rv_fetch_pkg;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
    localparam logic [31:0] INSTR_BYTES  = 32'd4;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        misalign;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory, redirect and decode handshake signals of the fetch stage
interface fetch_unit_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_misalign;
    modport master (
        output imem_addr, if_valid, if_pc, if_instr, if_misalign,
        input  imem_rdata, redirect_valid, redirect_pc, if_ready
    );
    modport slave (
        input  imem_addr, if_valid, if_pc, if_instr, if_misalign,
        output imem_rdata, redirect_valid, redirect_pc, if_ready
    );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: circular fetch queue of fetch_entry_t with push/pop/flush; flush wins over both
module fetch_fifo import rv_fetch_pkg::*; #(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output fetch_entry_t dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    logic [AW-1:0] rd, wr;
    logic [AW:0]   count;
    fetch_entry_t  mem [DEPTH];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd    <= '0;
            wr    <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            rd    <= '0;
            wr    <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wr] <= din;
                wr      <= wr + 1'b1;
            end
            if (pop) rd <= rd + 1'b1;
            if (push & !pop) count <= count + 1'b1;
            else if (pop & !push) count <= count - 1'b1;
        end
    end
    assign dout  = mem[rd];
    assign full  = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: owns fetch PC, drives imem address, queues {pc,instr} to decode, takes redirects
// MISALIGN_TRAP_EN: misaligned fetch pushes one NOP fault entry and halts until the next redirect
module fetch_unit import rv_fetch_pkg::*; #(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          FQ_DEPTH = 2
) (
    input logic          clk,
    input logic          rst,
    fetch_unit_if.master bus
);
`ifdef MISALIGN_TRAP_EN
    localparam logic TRAP = 1'b1;
`else
    localparam logic TRAP = 1'b0;
`endif
    logic [31:0]  fetch_pc, load_pc;
    logic         halted, push, pop, full, empty, mis;
    fetch_entry_t entry, head;
    assign mis     = TRAP & (fetch_pc[1:0] != 2'b00);
    assign load_pc = TRAP ? bus.redirect_pc : {bus.redirect_pc[31:2], 2'b00};
    assign pop     = !empty & bus.if_ready;
    assign push    = !halted & (!full | pop) & !bus.redirect_valid;
    assign entry   = '{pc: fetch_pc, instr: mis ? NOP_INSTR : bus.imem_rdata, misalign: mis};
    // a fault entry leaves fetch_pc parked on the misaligned address
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            halted   <= 1'b0;
        end else if (bus.redirect_valid) begin
            fetch_pc <= load_pc;
            halted   <= 1'b0;
        end else if (push) begin
            fetch_pc <= mis ? fetch_pc : fetch_pc + INSTR_BYTES;
            halted   <= mis;
        end
    end
    fetch_fifo #(.DEPTH(FQ_DEPTH)) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .pop  (pop),
        .flush(bus.redirect_valid),
        .din  (entry),
        .dout (head),
        .full (full),
        .empty(empty)
    );
    assign bus.imem_addr   = fetch_pc;
    assign bus.if_valid    = !empty;
    assign bus.if_pc       = head.pc;
    assign bus.if_instr    = head.instr;
    assign bus.if_misalign = TRAP & head.misalign;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus for fetch_unit against a queue-level model of the fetch rules
module tb_fetch_unit;
    localparam int D = 2;
`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        mis;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    fetch_unit_if bus ();
    fetch_unit #(.RESET_PC(32'h0), .FQ_DEPTH(D)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    logic [7:0] imem [256];
    logic [7:0] a0, a1, a2, a3;
    assign a0 = bus.imem_addr[7:0];
    assign a1 = a0 + 8'd1;
    assign a2 = a0 + 8'd2;
    assign a3 = a0 + 8'd3;
    assign bus.imem_rdata = {imem[a3], imem[a2], imem[a1], imem[a0]};

    initial begin
        for (int k = 0; k < 64; k++) begin
            logic [31:0] w;
            w = 32'hA000_0000 + k;
            imem[4*k]   = w[7:0];
            imem[4*k+1] = w[15:8];
            imem[4*k+2] = w[23:16];
            imem[4*k+3] = w[31:24];
        end
    end

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return 32'hA000_0000 + {26'd0, a[7:2]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    ent_t        q[$];
    logic [31:0] mpc = 32'h0;
    bit          mhalt = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            mpc   = 32'h0;
            mhalt = 1'b0;
        end else if (bus.redirect_valid) begin
            q.delete();
            mpc   = TRAP ? bus.redirect_pc : (bus.redirect_pc & ~32'd3);
            mhalt = 1'b0;
        end else begin
            bit pop, push;
            pop  = (q.size() != 0) && bus.if_ready;
            push = !mhalt && (q.size() < D || pop);
            if (pop) void'(q.pop_front());
            if (push) begin
                if (mpc[1:0] != 2'b00) begin
                    q.push_back('{pc: mpc, instr: 32'h13, mis: 1'b1});
                    mhalt = 1'b1;
                end else begin
                    q.push_back('{pc: mpc, instr: word_at(mpc), mis: 1'b0});
                    mpc = mpc + 32'd4;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("m_addr", bus.imem_addr, mpc);
            chk("m_valid", {31'd0, bus.if_valid}, {31'd0, q.size() != 0});
            if (q.size() != 0) begin
                chk("m_pc", bus.if_pc, q[0].pc);
                chk("m_instr", bus.if_instr, q[0].instr);
                chk("m_mis", {31'd0, bus.if_misalign}, {31'd0, q[0].mis});
            end
        end
    end

    task automatic redirect(input logic [31:0] t);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = t;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
    endtask

    initial begin
        bit [15:0] pat;
        pat = 16'b1011_0010_1110_0101;
        bus.if_ready       = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_valid", {31'd0, bus.if_valid}, 32'd0);
        chk("rst_pc", bus.if_pc, 32'd0);
        chk("rst_instr", bus.if_instr, 32'd0);
        chk("rst_mis", {31'd0, bus.if_misalign}, 32'd0);
        chk("rst_addr", bus.imem_addr, 32'd0);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t1_valid", {31'd0, bus.if_valid}, 32'd1);
            chk("t1_pc", bus.if_pc, 32'(4 * k));
            chk("t1_instr", bus.if_instr, 32'hA000_0000 + k);
        end
        bus.if_ready = 1'b0;
        #1 rst = 1'b1;
        #1 chk("t6a_valid", {31'd0, bus.if_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("t2_addr", bus.imem_addr, 32'h8);
        chk("t2_pc", bus.if_pc, 32'h0);
        chk("t2_valid", {31'd0, bus.if_valid}, 32'd1);
        redirect(32'h40);
        bus.if_ready = 1'b1;
        chk("t3_valid", {31'd0, bus.if_valid}, 32'd0);
        chk("t3_addr", bus.imem_addr, 32'h40);
        @(negedge clk);
        chk("t3_pc0", bus.if_pc, 32'h40);
        chk("t3_instr0", bus.if_instr, 32'hA000_0010);
        @(negedge clk);
        chk("t3_pc1", bus.if_pc, 32'h44);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h20;
        @(negedge clk);
        redirect(32'h60);
        @(negedge clk);
        chk("b2b_pc", bus.if_pc, 32'h60);
        redirect(32'hFFFF_FFF8);
        @(negedge clk);
        chk("t4_pc0", bus.if_pc, 32'hFFFF_FFF8);
        chk("t4_instr0", bus.if_instr, 32'hA000_003E);
        @(negedge clk);
        chk("t4_pc1", bus.if_pc, 32'hFFFF_FFFC);
        chk("t4_instr1", bus.if_instr, 32'hA000_003F);
        @(negedge clk);
        chk("t4_pc2", bus.if_pc, 32'h0);
        chk("t4_instr2", bus.if_instr, 32'hA000_0000);
        redirect(32'h42);
        @(negedge clk);
`ifdef MISALIGN_TRAP_EN
        chk("t5_pc", bus.if_pc, 32'h42);
        chk("t5_instr", bus.if_instr, 32'h13);
        chk("t5_mis", {31'd0, bus.if_misalign}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t5_halt_valid", {31'd0, bus.if_valid}, 32'd0);
            chk("t5_halt_addr", bus.imem_addr, 32'h42);
        end
`else
        chk("t5_pc", bus.if_pc, 32'h40);
        chk("t5_instr", bus.if_instr, 32'hA000_0010);
        chk("t5_mis", {31'd0, bus.if_misalign}, 32'd0);
        @(negedge clk);
        chk("t5_pc1", bus.if_pc, 32'h44);
`endif
        redirect(32'h80);
        @(negedge clk);
        chk("t5_resume", bus.if_pc, 32'h80);
        for (int k = 0; k < 16; k++) begin
            bus.if_ready = pat[k];
            if (k == 9) redirect(32'h10);
            else @(negedge clk);
        end
        bus.if_ready = 1'b0;
        redirect(32'h30);
        @(negedge clk);
        #1 rst = 1'b1;
        #1 chk("t6_valid", {31'd0, bus.if_valid}, 32'd0);
        chk("t6_addr", bus.imem_addr, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        bus.if_ready = 1'b1;
        @(negedge clk);
        chk("t6_pc", bus.if_pc, 32'h0);
        chk("t6_instr", bus.if_instr, 32'hA000_0000);
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
